// File: rtl/apb_cmd_arbiter_if.sv
// APB4 bus bundle for apb_cmd_arbiter.
//   master modport: paddr, pwrite, psel, penable, pwdata, pstrb out;
//                   prdata, pready, pslverr in.
//   slave modport : mirror of master.
interface apb_cmd_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32,
  parameter int unsigned SW = 4
);
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_cmd_arbiter.sv
// Two-requester round-robin APB4 master.
// Port 0 = UART command parser, port 1 = local init/script master.
// Each requester pulses mX_cmd_en with mX_we/addr/wdata/strb held stable and
// waits for the one-cycle mX_cmd_done; mX_rdata/mX_err are valid from then on.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mX_cmd_en/we/addr/wdata/strb   requester X command inputs (X = 0,1)
//   mX_cmd_done/rdata/err          requester X completion outputs
//   apb                   APB4 master side (apb_cmd_arbiter_if.master)
//   busy                  transfer in progress (FSM not idle)
//   grant                 index of the port owning the current/last transfer
// Build option: define APB_ARB_TIMEOUT_EN to force completion with error and
// all-ones read data after TIMEOUT_CYC ACCESS cycles without pready.
module apb_cmd_arbiter #(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 32,
  parameter int unsigned SW          = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_cmd_en,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [SW-1:0] m0_strb,
  output logic          m0_cmd_done,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_cmd_en,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [SW-1:0] m1_strb,
  output logic          m1_cmd_done,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  apb_cmd_arbiter_if.master apb,
  output logic          busy,
  output logic          grant
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_e;

  state_e        state_q;
  logic [1:0]    pend_q, pend_d, take;
  logic          sel;
  logic          grant_q, last_q, busy_q;
  logic          psel_q, penable_q, we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q, m0_rdata_q, m1_rdata_q;
  logic [SW-1:0] strb_q;
  logic          xerr_q, m0_err_q, m1_err_q, m0_done_q, m1_done_q;
`ifdef APB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0]   cnt_q;
`endif

  // Selection and pending bookkeeping; a cmd_en on the grant edge re-arms
  // the bit because the set term is OR-ed after the clear.
  always_comb begin
    sel = (pend_q == 2'b11) ? ~last_q : pend_q[1];
    take = '0;
    if (state_q == S_IDLE && pend_q != '0) take[sel] = 1'b1;
    pend_d = (pend_q & ~take) | {m1_cmd_en, m0_cmd_en};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      busy_q     <= 1'b0;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
      xerr_q     <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
      m0_done_q  <= 1'b0;
      m1_done_q  <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      pend_q    <= pend_d;
      m0_done_q <= 1'b0;
      m1_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pend_q != '0) begin
            grant_q <= sel;
            last_q  <= sel;
            we_q    <= sel ? m1_we : m0_we;
            addr_q  <= sel ? m1_addr : m0_addr;
            wdata_q <= sel ? m1_wdata : m0_wdata;
            if (sel ? m1_we : m0_we) strb_q <= sel ? m1_strb : m0_strb;
            else                     strb_q <= '0;
            psel_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        S_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (apb.pready) begin
            if (!we_q) rdata_q <= apb.prdata;
            xerr_q    <= apb.pslverr;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= S_DONE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            if (!we_q) rdata_q <= '1;
            xerr_q    <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
`endif
        end
        S_DONE: begin
          if (grant_q) begin
            m1_done_q <= 1'b1;
            m1_err_q  <= xerr_q;
            if (!we_q) m1_rdata_q <= rdata_q;
          end else begin
            m0_done_q <= 1'b1;
            m0_err_q  <= xerr_q;
            if (!we_q) m0_rdata_q <= rdata_q;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign apb.paddr   = addr_q;
  assign apb.pwrite  = we_q;
  assign apb.psel    = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwdata  = wdata_q;
  assign apb.pstrb   = strb_q;
  assign m0_cmd_done = m0_done_q;
  assign m1_cmd_done = m1_done_q;
  assign m0_rdata    = m0_rdata_q;
  assign m1_rdata    = m1_rdata_q;
  assign m0_err      = m0_err_q;
  assign m1_err      = m1_err_q;
  assign busy        = busy_q;
  assign grant       = grant_q;

endmodule
